// File: rtl/char_map_pkg.sv
// rtl/char_map_pkg.sv - shared types and helpers for the multi-port character map
package char_map_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Low bit of port k's slice in a packed multi-port bus of w-bit fields.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

   function automatic int slice_hi(input int k, input int w);
      return (k * w) + w - 1;
   endfunction

endpackage

// File: rtl/char_map_clear_seq.sv
// rtl/char_map_clear_seq.sv - clear/idle sequencer sweeping one table entry per cycle
module char_map_clear_seq
   import char_map_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_req_i,
   output state_e            state_o,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clr_req_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Table contents must stay untouched while reset is held.
   assign clr_we_o   = (state_q == ST_CLEAR) && !rst_i;
   assign clr_addr_o = cnt_q;
   assign busy_o     = rst_i || (state_q == ST_CLEAR);
   assign state_o    = state_q;

endmodule

// File: rtl/char_map_mp.sv
// rtl/char_map_mp.sv - multi-read-port charset lookup table with clear sweep and length tracking
module char_map_mp
   import char_map_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NUM_RD = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_req_i,
   output logic                     busy_o,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [ADDR_W-1:0]        wr_pos_i,
   input  logic [DATA_W-1:0]        wr_val_i,
   input  logic                     rd_en_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_pos_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic                     rd_valid_o,
   output logic [ADDR_W:0]          map_len_o
);

   localparam int DEPTH = depth_of(ADDR_W);

   state_e            state;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              idle;
   logic              wr_fire;
   logic              rd_fire;

   char_map_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_req_i  (clr_req_i),
      .state_o    (state),
      .busy_o     (busy_o),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   assign idle       = (state == ST_IDLE);
   assign wr_ready_o = idle && !clr_req_i && !rst_i;
   assign wr_fire    = wr_valid_i && wr_ready_o;
   assign rd_fire    = rd_en_i && idle && !rst_i;

   // Sweep and host write are mutually exclusive by state; the sweep wins regardless.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_fire) begin
         mem_q[wr_pos_i] <= wr_val_i;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] pos;
      logic [DATA_W-1:0] rdata_d, rdata_q;

      assign pos     = rd_pos_i[slice_lo(k, ADDR_W) +: ADDR_W];
      // Write-through so a same-cycle write is visible to readers of that index.
      assign rdata_d = (wr_fire && (wr_pos_i == pos)) ? wr_val_i : mem_q[pos];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rdata_q <= '0;
         end else if (rd_fire) begin
            rdata_q <= rdata_d;
         end
      end

      assign rd_data_o[slice_lo(k, DATA_W) +: DATA_W] = rst_i ? '0 : rdata_q;
   end

   logic rd_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
      end
   end

   assign rd_valid_o = rd_valid_q && !rst_i;

   logic [ADDR_W:0] map_len_q, map_len_d;
   logic [ADDR_W:0] wr_len;

   assign wr_len = {1'b0, wr_pos_i} + (ADDR_W + 1)'(1);

   always_comb begin
      map_len_d = map_len_q;
      if (idle && clr_req_i) begin
         map_len_d = '0;
      end else if (wr_fire && (wr_len > map_len_q)) begin
         map_len_d = wr_len;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         map_len_q <= '0;
      end else begin
         map_len_q <= map_len_d;
      end
   end

   assign map_len_o = rst_i ? '0 : map_len_q;

endmodule

// File: tb/tb_char_map_mp.sv
// tb/tb_char_map_mp.sv - directed and randomized checks of char_map_mp against a table model
module tb_char_map_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr_req, busy, wr_valid, wr_ready, rd_en, rd_valid;
   logic [7:0]  wr_pos, wr_val;
   logic [31:0] rd_pos, rd_data;
   logic [8:0]  map_len;

   logic        clr2, busy2, wr_valid2, wr_ready2, rd_en2, rd_valid2;
   logic [5:0]  wr_pos2;
   logic [7:0]  wr_val2;
   logic [47:0] rd_pos2;
   logic [63:0] rd_data2;
   logic [6:0]  map_len2;

   int total = 0;
   int bad   = 0;

   logic [7:0] ref_mem [256];
   int         ref_len;
   logic [7:0] ref2 [64];
   int         ref_len2;

   char_map_mp u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_req_i  (clr_req),
      .busy_o     (busy),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready),
      .wr_pos_i   (wr_pos),
      .wr_val_i   (wr_val),
      .rd_en_i    (rd_en),
      .rd_pos_i   (rd_pos),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .map_len_o  (map_len)
   );

   char_map_mp #(
      .DATA_W (8),
      .ADDR_W (6),
      .NUM_RD (8)
   ) u_dut2 (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_req_i  (clr2),
      .busy_o     (busy2),
      .wr_valid_i (wr_valid2),
      .wr_ready_o (wr_ready2),
      .wr_pos_i   (wr_pos2),
      .wr_val_i   (wr_val2),
      .rd_en_i    (rd_en2),
      .rd_pos_i   (rd_pos2),
      .rd_data_o  (rd_data2),
      .rd_valid_o (rd_valid2),
      .map_len_o  (map_len2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      ref_len = 0;
   endtask

   // One cycle on the 4-port table: optional write, optional read, then compare.
   task automatic acc(input bit dw, input logic [7:0] wp, input logic [7:0] wv,
                      input bit dr, input logic [31:0] rp);
      wr_valid = dw; wr_pos = wp; wr_val = wv; rd_en = dr; rd_pos = rp;
      #1;
      if (dw) chk("wr_ready", wr_ready, 1);
      tick();
      wr_valid = 1'b0; rd_en = 1'b0;
      if (dw) begin
         ref_mem[wp] = wv;
         if (int'(wp) + 1 > ref_len) ref_len = int'(wp) + 1;
      end
      chk("rd_valid", rd_valid, dr);
      if (dr) begin
         for (int k = 0; k < 4; k++) chk("rd_data", rd_data[k*8 +: 8], ref_mem[rp[k*8 +: 8]]);
      end
      chk("map_len", map_len, ref_len);
   endtask

   task automatic acc2(input bit dw, input logic [5:0] wp, input logic [7:0] wv,
                       input bit dr, input logic [47:0] rp);
      wr_valid2 = dw; wr_pos2 = wp; wr_val2 = wv; rd_en2 = dr; rd_pos2 = rp;
      #1;
      if (dw) chk("wr_ready2", wr_ready2, 1);
      tick();
      wr_valid2 = 1'b0; rd_en2 = 1'b0;
      if (dw) begin
         ref2[wp] = wv;
         if (int'(wp) + 1 > ref_len2) ref_len2 = int'(wp) + 1;
      end
      chk("rd_valid2", rd_valid2, dr);
      if (dr) begin
         for (int k = 0; k < 8; k++) chk("rd_data2", rd_data2[k*8 +: 8], ref2[rp[k*6 +: 6]]);
      end
      chk("map_len2", map_len2, ref_len2);
   endtask

   task automatic count_sweep(input string tag);
      int n;
      n = 0;
      while (busy && n < 400) begin
         n++;
         tick();
      end
      chk(tag, n, 256);
   endtask

   initial begin
      logic [31:0] rp;
      logic [47:0] rp2;
      logic [7:0]  wp, hold;
      logic [31:0] hold_word;
      int b1, b2, n;

      rst = 1'b1; clr_req = 1'b0; wr_valid = 1'b0; wr_pos = '0; wr_val = '0;
      rd_en = 1'b0; rd_pos = '0;
      clr2 = 1'b0; wr_valid2 = 1'b0; wr_pos2 = '0; wr_val2 = '0; rd_en2 = 1'b0; rd_pos2 = '0;
      model_clear();
      for (int i = 0; i < 64; i++) ref2[i] = 8'h00;
      ref_len2 = 0;

      // Reset state, then sweep length of both configurations.
      tick();
      tick();
      chk("rst_busy", busy, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_map_len", map_len, 0);
      chk("rst_busy2", busy2, 1);
      rst = 1'b0;
      #1;
      b1 = 0; b2 = 0;
      for (int i = 0; i < 300; i++) begin
         b1 += int'(busy);
         b2 += int'(busy2);
         tick();
      end
      chk("sweep_len_256", b1, 256);
      chk("sweep_len_64", b2, 64);

      for (int i = 0; i < 64; i++) begin
         rp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         acc(0, 0, 0, 1, rp);
      end
      acc(0, 0, 0, 0, 0);

      // Load and read.
      acc(1, 8'd0, 8'h61, 0, 0);
      acc(1, 8'd1, 8'h62, 0, 0);
      acc(1, 8'd25, 8'h7A, 0, 0);
      acc(0, 0, 0, 1, {8'd25, 8'd1, 8'd0, 8'd0});
      chk("load_word", rd_data, 32'h7A626161);
      chk("load_len", map_len, 9'd26);

      // Same-cycle write-through on ports 0 and 1.
      acc(1, 8'd3, 8'h41, 0, 0);
      acc(1, 8'd3, 8'h42, 1, {8'd25, 8'd1, 8'd3, 8'd3});
      chk("bypass_word", rd_data, 32'h7A624242);

      // Randomized mix of writes and reads, with frequent index collisions.
      for (int i = 0; i < 80; i++) begin
         wp = 8'($urandom_range(63, 0));
         for (int k = 0; k < 4; k++) begin
            rp[k*8 +: 8] = ($urandom_range(2, 0) == 0) ? wp : 8'($urandom_range(63, 0));
         end
         acc(bit'($urandom_range(1, 0)), wp, 8'($urandom), bit'($urandom_range(1, 0)), rp);
      end

      // Length boundary.
      acc(1, 8'd255, 8'hFF, 1, {8'd255, 8'd255, 8'd255, 8'd255});
      chk("len_full", map_len, 9'h100);
      acc(1, 8'd10, 8'h5A, 0, 0);
      chk("len_hold", map_len, 9'h100);

      // Clear has priority over a same-cycle write.
      acc(0, 0, 0, 1, {8'd255, 8'd10, 8'd3, 8'd0});
      hold_word = rd_data;
      clr_req = 1'b1; wr_valid = 1'b1; wr_pos = 8'd5; wr_val = 8'h55;
      #1;
      chk("clr_wr_ready", wr_ready, 0);
      tick();
      clr_req = 1'b0; wr_valid = 1'b0;
      model_clear();
      n = 0;
      while (busy && n < 400) begin
         rd_en = 1'b1;
         n++;
         tick();
         chk("sweep_rd_valid", rd_valid, 0);
         chk("sweep_rd_hold", rd_data, hold_word);
         chk("sweep_map_len", map_len, 0);
      end
      rd_en = 1'b0;
      chk("clr_sweep_len", n, 256);
      acc(0, 0, 0, 1, {8'd5, 8'd255, 8'd10, 8'd5});

      // In-flight read dropped by reset, then full restart.
      acc(1, 8'd7, 8'h77, 0, 0);
      rd_en = 1'b1; rd_pos = {8'd7, 8'd7, 8'd7, 8'd7};
      tick();
      rd_en = 1'b0;
      chk("inflight_rd_valid", rd_valid, 1);
      rst = 1'b1;
      tick();
      chk("rst_drop_rd_valid", rd_valid, 0);
      chk("rst_drop_rd_data", rd_data, 0);
      chk("rst_drop_map_len", map_len, 0);
      rst = 1'b0;
      #1;
      count_sweep("rst_sweep_len");

      // Reset in the middle of a clear sweep.
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      chk("mid_sweep_busy", busy, 1);
      rst = 1'b1;
      tick();
      tick();
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_map_len", map_len, 0);
      rst = 1'b0;
      #1;
      count_sweep("mid_rst_sweep_len");
      model_clear();
      acc(0, 0, 0, 1, {8'd255, 8'd128, 8'd7, 8'd0});

      // Eight-port, 64-entry configuration.
      chk("cfg2_idle", busy2, 0);
      for (int i = 0; i < 64; i++) acc2(1, 6'(i), 8'($urandom), 0, 0);
      chk("cfg2_len", map_len2, 7'd64);
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 8; k++) rp2[k*6 +: 6] = 6'($urandom_range(63, 0));
         acc2(0, 0, 0, 1, rp2);
      end
      acc2(0, 0, 0, 1, {8{6'd33}});
      wp = 8'($urandom_range(63, 0));
      acc2(1, wp[5:0], 8'hC3, 1, {wp[5:0], 6'd1, wp[5:0], 6'd2, wp[5:0], 6'd3, wp[5:0], 6'd4});

      hold = rd_data2[7:0];
      chk("cfg2_hold", rd_data2[7:0], hold);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/char_map_mp.md
Name: char_map_mp

Overview:
Parametrised multi-read-port character map for the candidate generator. It is a DEPTH-entry lookup table that turns per-position charset indices into password bytes, giving NUM_RD lookups per cycle so one cycle serves several password positions. It adds registered reads, a write handshake, a hardware clear sequencer and a loaded-length tracker. It sits between the host charset-load interface and the candidate-word assembly pipeline.

Parameters:
DATA_W, 8, width of each stored character
ADDR_W, 8, index width; DEPTH = 2**ADDR_W entries
NUM_RD, 4, number of independent read ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr_req  in  1  request a full table clear; sampled only in IDLE
busy  out  1  high while reset is active or the clear sweep is running
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_pos  in  ADDR_W  write index
wr_val  in  DATA_W  write data
rd_en  in  1  read request, applies to all ports
rd_pos  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, same packing as rd_pos
rd_valid  out  1  rd_data is valid this cycle
map_len  out  ADDR_W+1  highest written index + 1; 0 when the table is empty

Behaviour:
- States: CLEAR and IDLE. rst high forces CLEAR with sweep counter = 0.
- While rst is high: busy=1, wr_ready=0, rd_valid=0, rd_data=0, map_len=0. Table contents are not written during reset.
- CLEAR: one entry is zeroed per cycle at the counter address, then the counter increments.
  - After entry DEPTH-1 is written, the next state is IDLE.
  - The sweep takes exactly DEPTH cycles after rst falls, so busy deasserts in cycle DEPTH+1.
  - map_len is held at 0 throughout the sweep.
- IDLE with clr_req=1: next state is CLEAR with the counter reset to 0 and map_len reset to 0.
- clr_req is ignored in CLEAR.
- wr_ready = (state==IDLE) && !clr_req && !rst. This is combinational and does not depend on wr_valid.
- Accepted write: entry[wr_pos] <= wr_val. map_len <= max(map_len, wr_pos+1), computed at ADDR_W+1 bits, so writing wr_pos=DEPTH-1 gives map_len=DEPTH with no wrap.
- Read timing:
  - Latency is 1 cycle. rd_valid(t+1) = rd_en(t) && state(t)==IDLE && !rst(t).
  - rd_en during busy produces no rd_valid, and rd_data holds its last value.
  - rd_data updates only when rd_valid is asserted next cycle; otherwise it holds.
- Read-during-write, same cycle and same index on port k: rd_data[k] returns the new wr_val (write-through bypass). Ports with different indices return the stored contents.
- Reads of indices >= map_len are legal and return the stored value (0 after a clear).
- Several ports reading the same index in one cycle all return the same value.
- Reset asserted mid-sweep or mid-write: the sweep restarts from 0 and any in-flight rd_valid is dropped the cycle after rst rises.
- Storage is plain flops or distributed RAM with NUM_RD read muxes. Block RAM is not used because it would need more than 2 ports.

Decomposition:
- Shared package char_map_pkg holds:
  - state encoding constants ST_CLEAR and ST_IDLE
  - a function for DEPTH from ADDR_W
  - pack/unpack helpers for the port-k slice.
- Sub-module char_map_clear_seq holds the state FSM, the ADDR_W-bit sweep counter, busy, and clear address/write-enable generation.
- The top level owns storage, the write arbitration between the sweep and the host write, the bypass logic, the read registers and map_len.

Test Plan:
1. Reset then idle, default params: rst for 2 cycles, then wait -> busy=1 for exactly 256 cycles after rst falls. Every read of indices 0..255 then returns 0 with rd_valid one cycle after rd_en, and map_len=0.
2. Load and read: write pos0=0x61, pos1=0x62, pos25=0x7A, then rd_en with rd_pos={25,1,0,0} -> next cycle rd_data={7A,62,61,61}, rd_valid=1, map_len=26.
3. Bypass: pos3 holds 0x41. In the same cycle write pos3=0x42 and read ports 0 and 1 at index 3 -> both return 0x42, and other ports return their stored values.
4. Length boundary: write pos255=0xFF -> map_len=256 (9'h100). A following write of pos10 leaves map_len=256.
5. Clear priority: in IDLE assert clr_req with wr_valid (pos5=0x55) -> wr_ready=0 and the write is dropped. busy=1 for 256 cycles, rd_en during the sweep yields no rd_valid, and pos5 reads 0 afterwards.
6. Reset mid-sweep: assert rst at sweep cycle 100 -> busy stays 1, and the sweep restarts and completes 256 cycles after rst falls. Then test NUM_RD=8, ADDR_W=6 -> the sweep takes 64 cycles and all 8 ports return independently written values.
